upcounter_event_source: RTL and testbench

- Fabric-side source that drives the HPS upcounter component's two inputs: `counter_input`, a one-cycle count pulse, and `irq_input`, a level interrupt request.
- Event source is either a debounced pushbutton or a prescaled periodic tick.
- Groups every IRQ_EVERY events into one interrupt request, held until software acknowledges it through a PIO bit.
- Sits in the top level between board keys/PIO and the soc_system upcounter conduit.

---
 rtl/upcounter_event_pkg.sv | 17 +
 rtl/upcounter_event_source_key_debounce.sv | 84 ++++++++
 rtl/upcounter_event_source.sv | 91 +++++++++
 tb/tb_upcounter_event_source.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upcounter_event_pkg.sv
// Shared types and width helpers for the upcounter event source.
// Imported by the debounce sub-block and the top.
package upcounter_event_pkg;

   typedef enum logic [1:0] {
      REL   = 2'd0,
      CHK_P = 2'd1,
      PRS   = 2'd2,
      CHK_R = 2'd3
   } deb_state_e;

   // Counter width for values 0..limit-1, never narrower than one bit.
   function automatic int cnt_w(input int limit);
      return (limit < 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/upcounter_event_source_key_debounce.sv
// Pushbutton synchroniser and debounce FSM.
// press_evt pulses once per accepted press; key_level is the debounced level.
module key_debounce
   import upcounter_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press_evt,
   output logic key_level
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          key_s_q, key_s_d;
   deb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable;

   always_comb begin
      sync1_d   = key_n;
      key_s_d   = sync1_q;
      stable    = (cnt_q == CNT_LAST);
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
         REL: begin
            if (!key_s_q) begin
               state_d = CHK_P;
               cnt_d   = '0;
            end
         end
         CHK_P: begin
            if (key_s_q) begin
               state_d = REL;
            end else if (stable) begin
               state_d   = PRS;
               press_evt = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRS: begin
            if (key_s_q) begin
               state_d = CHK_R;
               cnt_d   = '0;
            end
         end
         CHK_R: begin
            if (!key_s_q) begin
               state_d = PRS;
            end else if (stable) begin
               state_d = REL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = REL;
      endcase
   end

   assign key_level = (state_q == PRS) || (state_q == CHK_R);

   // Synchroniser resets to the released level so reset release is silent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         key_s_q <= 1'b1;
         state_q <= REL;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         key_s_q <= key_s_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/upcounter_event_source.sv
// Drives the HPS upcounter count pulse and IRQ from a debounced key or tick.
// Every IRQ_EVERY events raise an IRQ held until software acknowledges it.
module upcounter_event_source
   import upcounter_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 50000000,
   parameter int IRQ_EVERY       = 10,
   parameter int EVT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_n,
   input  logic             mode,
   input  logic             enable,
   input  logic             irq_ack,
   output logic             counter_input,
   output logic             irq_input,
   output logic             irq_overrun,
   output logic [EVT_W-1:0] evt_count
);

   localparam int PW = cnt_w(TICK_DIV);
   localparam int EW = cnt_w(IRQ_EVERY);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [EW-1:0] EVT_LAST = EW'(IRQ_EVERY - 1);

   logic          press_evt;
   logic [PW-1:0] pre_q, pre_d;
   logic          mode_q, mode_d;
   logic [EW-1:0] cnt_q, cnt_d;
   logic          ci_q, ci_d;
   logic          irq_q, irq_d;
   logic          ovr_q, ovr_d;
   logic          run;
   logic          tick_evt;
   logic          evt;
   logic          irq_evt;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk       (clk),
      .reset     (reset),
      .key_n     (key_n),
      .press_evt (press_evt),
      .key_level ()
   );

   always_comb begin
      mode_d   = mode;
      // A mode edge holds the prescaler at 0 for one cycle.
      run      = enable & mode & (mode == mode_q);
      tick_evt = run & (pre_q == PRE_LAST);
      pre_d    = (!run || tick_evt) ? '0 : pre_q + 1'b1;
      evt      = enable & (mode ? tick_evt : press_evt);
      irq_evt  = evt & (cnt_q == EVT_LAST);
      cnt_d    = cnt_q;
      if (evt) begin
         cnt_d = irq_evt ? '0 : cnt_q + 1'b1;
      end
      ci_d  = evt;
      // A new IRQ beats a same-cycle ack; the ack still clears overrun.
      irq_d = irq_evt | (irq_q & ~irq_ack);
      ovr_d = ~irq_ack & (ovr_q | (irq_evt & irq_q));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
         ci_q   <= 1'b0;
         irq_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         ci_q   <= ci_d;
         irq_q  <= irq_d;
         ovr_q  <= ovr_d;
      end
   end

   assign counter_input = ci_q;
   assign irq_input     = irq_q;
   assign irq_overrun   = ovr_q;
   assign evt_count     = EVT_W'(cnt_q);

endmodule

// File: tb/tb_upcounter_event_source.sv
// Randomised and directed bench for upcounter_event_source.
// A run-length / modulo reference model predicts every output each cycle.
module tb_upcounter_event_source;

   localparam int D = 4;
   localparam int T = 5;
   localparam int I = 3;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         key_n;
   logic         mode;
   logic         enable;
   logic         irq_ack;
   logic         counter_input;
   logic         irq_input;
   logic         irq_overrun;
   logic [W-1:0] evt_count;

   int vecs = 0;
   int errs = 0;
   int ncyc = 0;

   // Reference model state
   bit           kh0, kh1;
   bit           lvl;
   bit           pm;
   int           run_len;
   int           k;
   int           nevt;
   bit           m_ci, m_irq, m_ovr;
   logic [W-1:0] m_cnt;

   always #5 clk = ~clk;

   upcounter_event_source #(
      .DEBOUNCE_CYCLES(D),
      .TICK_DIV       (T),
      .IRQ_EVERY      (I),
      .EVT_W          (W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_n         (key_n),
      .mode          (mode),
      .enable        (enable),
      .irq_ack       (irq_ack),
      .counter_input (counter_input),
      .irq_input     (irq_input),
      .irq_overrun   (irq_overrun),
      .evt_count     (evt_count)
   );

   task automatic model_reset();
      kh0 = 1'b1; kh1 = 1'b1;
      lvl = 1'b0; pm = 1'b0;
      run_len = 0; k = 0; nevt = 0;
      m_ci = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; m_cnt = '0;
   endtask

   // One clock: predict from this cycle's inputs, clock, compare outputs.
   task automatic step();
      bit ks, press, tick, evt, ievt;
      ks = kh1;
      press = 1'b0;
      // Debounced level flips after D+1 consecutive disagreeing samples.
      if ((ks == 1'b0) != lvl) run_len++;
      else run_len = 0;
      if (run_len == D + 1) begin
         lvl = !lvl;
         run_len = 0;
         press = lvl;
      end
      if (enable && mode && (mode == pm)) k++;
      else k = 0;
      tick = (k > 0) && (k % T == 0);
      pm = mode;
      evt = enable && (mode ? tick : press);
      ievt = evt && ((nevt + 1) % I == 0);
      if (evt) nevt++;
      m_ovr = (irq_ack && m_irq) ? 1'b0 : (m_ovr | (ievt && m_irq));
      m_irq = ievt ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
      m_ci = evt;
      m_cnt = W'(nevt % I);
      kh1 = kh0;
      kh0 = key_n;
      @(posedge clk);
      #1;
      ncyc++;
      vecs++;
      if ({counter_input, irq_input, irq_overrun, evt_count} !==
          {m_ci, m_irq, m_ovr, m_cnt}) begin
         errs++;
         $display("FAIL model cyc=%0d ci/irq/ovr/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                  ncyc, counter_input, irq_input, irq_overrun, evt_count,
                  m_ci, m_irq, m_ovr, m_cnt);
      end
   endtask

   task automatic test_reset();
      int np;
      vecs++;
      if ({counter_input, irq_input, irq_overrun, evt_count} !== '0) begin
         errs++;
         $display("FAIL reset_init got %b want 0",
                  {counter_input, irq_input, irq_overrun, evt_count});
      end
      reset = 1'b0;
      key_n = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      #1;
      model_reset();
      vecs++;
      if ({counter_input, irq_input, irq_overrun, evt_count} !== '0) begin
         errs++;
         $display("FAIL reset_mid got %b want 0",
                  {counter_input, irq_input, irq_overrun, evt_count});
      end
      repeat (2) @(posedge clk);
      #1;
      key_n = 1'b1;
      reset = 1'b0;
      np = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (counter_input) np++;
      end
      vecs++;
      if (np !== 0) begin
         errs++;
         $display("FAIL reset_release pulses got %0d want 0", np);
      end
   endtask

   task automatic test_bounce();
      int np, at;
      mode = 1'b0;
      enable = 1'b1;
      key_n = 1'b0; step(); step();
      key_n = 1'b1; step();
      key_n = 1'b0;
      np = 0; at = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (counter_input) begin np++; at = i; end
      end
      vecs++;
      if (np !== 1) begin
         errs++;
         $display("FAIL bounce_press pulses got %0d want 1", np);
      end
      vecs++;
      if (at < 6 || at > 8) begin
         errs++;
         $display("FAIL bounce_latency got %0d want 7+-1", at);
      end
      key_n = 1'b1; step(); step();
      key_n = 1'b0; step();
      key_n = 1'b1;
      np = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (counter_input) np++;
      end
      vecs++;
      if (np !== 0) begin
         errs++;
         $display("FAIL bounce_release pulses got %0d want 0", np);
      end
   endtask

   task automatic test_tick();
      int np, last;
      int at[4];
      logic [W-1:0] cv[4];
      bit iv[4];
      reset = 1'b1;
      mode = 1'b0;
      #1;
      model_reset();
      vecs++;
      if (evt_count !== '0) begin
         errs++;
         $display("FAIL tick_reset evt_count got %0d want 0", evt_count);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mode = 1'b1;
      enable = 1'b1;
      np = 0;
      for (int i = 1; i <= 30 && np < 4; i++) begin
         step();
         if (counter_input) begin
            at[np] = i; cv[np] = evt_count; iv[np] = irq_input; np++;
         end
      end
      vecs++;
      if (np !== 4) begin
         errs++;
         $display("FAIL tick_pulses got %0d want 4", np);
      end else begin
         vecs++;
         if (at[0] !== 6) begin
            errs++;
            $display("FAIL tick_first got %0d want 6", at[0]);
         end
         last = at[0];
         for (int j = 1; j < 4; j++) begin
            vecs++;
            if (at[j] - last !== T) begin
               errs++;
               $display("FAIL tick_gap%0d got %0d want %0d", j, at[j] - last, T);
            end
            last = at[j];
         end
         vecs++;
         if ({cv[0], cv[1], cv[2], cv[3]} !== {8'd1, 8'd2, 8'd0, 8'd1}) begin
            errs++;
            $display("FAIL tick_counts got %0d,%0d,%0d,%0d want 1,2,0,1",
                     cv[0], cv[1], cv[2], cv[3]);
         end
         vecs++;
         if ({iv[1], iv[2]} !== 2'b01) begin
            errs++;
            $display("FAIL tick_irq_rise got %b want 01", {iv[1], iv[2]});
         end
      end
   endtask

   task automatic test_overrun();
      int np;
      np = 4;
      for (int i = 0; i < 15 && np < 6; i++) begin
         step();
         if (counter_input) begin
            np++;
            if (np == 5) begin
               vecs++;
               if (irq_overrun !== 1'b0) begin
                  errs++;
                  $display("FAIL ovr_pulse5 got %b want 0", irq_overrun);
               end
            end
         end
      end
      vecs++;
      if (np !== 6 || irq_overrun !== 1'b1 || irq_input !== 1'b1) begin
         errs++;
         $display("FAIL ovr_pulse6 np/irq/ovr got %0d/%b/%b want 6/1/1",
                  np, irq_input, irq_overrun);
      end
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      vecs++;
      if ({irq_input, irq_overrun} !== 2'b00) begin
         errs++;
         $display("FAIL ovr_ack irq/ovr got %b want 00", {irq_input, irq_overrun});
      end
   endtask

   task automatic test_simultaneous();
      for (int p = 0; p < 2; p++) begin
         for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 12; i++) begin
               step();
               if (counter_input) break;
            end
            vecs++;
            if (counter_input !== 1'b1) begin
               errs++;
               $display("FAIL simul_wait got %b want 1", counter_input);
            end
         end
         repeat (4) step();
         irq_ack = 1'b1;
         step();
         irq_ack = 1'b0;
         vecs++;
         if ({counter_input, irq_input, irq_overrun} !== 3'b110) begin
            errs++;
            $display("FAIL simul_ack%0d ci/irq/ovr got %b want 110",
                     p, {counter_input, irq_input, irq_overrun});
         end
      end
   endtask

   task automatic test_enable_mode();
      logic [W-1:0] saved;
      int gap;
      for (int i = 0; i < 12; i++) begin
         step();
         if (counter_input) break;
      end
      repeat (3) step();
      saved = evt_count;
      enable = 1'b0;
      repeat (3) step();
      vecs++;
      if (evt_count !== saved) begin
         errs++;
         $display("FAIL en_hold evt_count got %0d want %0d", evt_count, saved);
      end
      enable = 1'b1;
      gap = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (counter_input) begin gap = i; break; end
      end
      vecs++;
      if (gap !== T) begin
         errs++;
         $display("FAIL en_restart gap got %0d want %0d", gap, T);
      end
      saved = evt_count;
      mode = 1'b0;
      repeat (2) step();
      mode = 1'b1;
      gap = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (counter_input) begin gap = i; break; end
      end
      vecs++;
      if (gap !== T + 1) begin
         errs++;
         $display("FAIL mode_restart gap got %0d want %0d", gap, T + 1);
      end
      vecs++;
      if (evt_count !== W'((saved + 1) % I)) begin
         errs++;
         $display("FAIL mode_count got %0d want %0d", evt_count, (saved + 1) % I);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      mode = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            key_n = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14)
                                               : $urandom_range(1, 4);
         end
         hold--;
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         irq_ack = ($urandom_range(0, 7) == 0);
         step();
      end
      irq_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout at cyc=%0d", ncyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      key_n = 1'b1;
      mode = 1'b0;
      enable = 1'b1;
      irq_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_bounce();
      test_tick();
      test_overrun();
      test_simultaneous();
      test_enable_mode();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
